// File: rtl/nibble_pkg.sv
// Shared types and constants for the byte-to-nibble FIFO feeder.
package nibble_pkg;

    localparam int BYTE_W        = 8;
    localparam int NIB_W         = 4;
    localparam int DEFAULT_DEPTH = 4;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HI   = 2'd1,
        S_LO   = 2'd2
    } nib_state_t;

endpackage

// File: rtl/byte_a_nibble_fifo_if.sv
// Byte-in / nibble-out handshake bundle; master drives bytes, slave is the FIFO.
interface byte_a_nibble_fifo_if;
    import nibble_pkg::*;

    logic              valid_in;
    logic [BYTE_W-1:0] data_in;
    logic              ready_out;
    logic              valid_out;
    logic [NIB_W-1:0]  data_out;
    logic              fifo_full;
    logic              fifo_empty;
    logic              overflow;

    modport master (
        output valid_in, data_in,
        input  ready_out, valid_out, data_out, fifo_full, fifo_empty, overflow
    );

    modport slave (
        input  valid_in, data_in,
        output ready_out, valid_out, data_out, fifo_full, fifo_empty, overflow
    );

endinterface

// File: rtl/fifo_sinc_bytes.sv
// Synchronous byte FIFO: storage, wrapping pointers and an occupancy count.
module fifo_sinc_bytes
    import nibble_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic              clk_4f,
    input  logic              reset,
    input  logic              push,
    input  logic              pop,
    input  logic [BYTE_W-1:0] wr_data,
    output logic [BYTE_W-1:0] rd_data,
    output logic              full,
    output logic              empty
);

    localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

    logic [BYTE_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr_reg;
    logic [AW-1:0]     rd_ptr_reg;
    logic [AW:0]       count_reg;
    logic [AW:0]       count_next;
    logic              push_ok;
    logic              pop_ok;

    assign full    = (count_reg == FULL_COUNT);
    assign empty   = (count_reg == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign rd_data = mem[rd_ptr_reg];

    always_ff @(posedge clk_4f) begin
        if (push_ok) begin
            mem[wr_ptr_reg] <= wr_data;
        end
    end

    always_comb begin
        count_next = count_reg;
        unique case ({push_ok, pop_ok})
            2'b10:   count_next = count_reg + 1'b1;
            2'b01:   count_next = count_reg - 1'b1;
            default: count_next = count_reg;
        endcase
    end

    // DEPTH is a power of two, so pointer overflow is the modulo wrap.
    always_ff @(posedge clk_4f or posedge reset) begin
        if (reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            count_reg <= count_next;
        end
    end

endmodule

// File: rtl/byte_a_nibble_fifo.sv
// Buffers bytes and emits them as two back-to-back nibbles; MSN first by default,
// LSN first when NIBBLE_LSN_FIRST_EN is defined.
module byte_a_nibble_fifo
    import nibble_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic                  clk_4f,
    input  logic                  reset,
    byte_a_nibble_fifo_if.slave   bus
);

`ifdef NIBBLE_LSN_FIRST_EN
    localparam int FIRST_IDX = 0;
`else
    localparam int FIRST_IDX = 1;
`endif
    localparam int SECOND_IDX = 1 - FIRST_IDX;

    nib_state_t        state_reg;
    nib_state_t        state_next;
    logic [BYTE_W-1:0] hold_reg;
    logic [BYTE_W-1:0] hold_next;
    logic [BYTE_W-1:0] head_byte;
    logic [NIB_W-1:0]  hold_nib [2];
    logic [NIB_W-1:0]  data_out_next;
    logic [NIB_W-1:0]  data_out_reg;
    logic              valid_out_reg;
    logic              overflow_reg;
    logic              full;
    logic              empty;
    logic              push;
    logic              pop;
    logic              drop;

    assign push = bus.valid_in && !full;
    assign drop = bus.valid_in && full;

    fifo_sinc_bytes #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_fifo (
        .clk_4f  (clk_4f),
        .reset   (reset),
        .push    (push),
        .pop     (pop),
        .wr_data (bus.data_in),
        .rd_data (head_byte),
        .full    (full),
        .empty   (empty)
    );

    always_comb begin
        state_next = state_reg;
        pop        = 1'b0;
        hold_next  = hold_reg;
        unique case (state_reg)
            S_IDLE: begin
                if (!empty) begin
                    pop        = 1'b1;
                    state_next = S_HI;
                end
            end
            S_HI: state_next = S_LO;
            S_LO: begin
                if (!empty) begin
                    pop        = 1'b1;
                    state_next = S_HI;
                end else begin
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
        if (pop) begin
            hold_next = head_byte;
        end
    end

    for (genvar gi = 0; gi < 2; gi++) begin : g_nib
        assign hold_nib[gi] = hold_next[gi*NIB_W +: NIB_W];
    end

    // Outputs are registered from the next state so valid_out tracks state != S_IDLE.
    always_comb begin
        data_out_next = '0;
        unique case (state_next)
            S_HI:    data_out_next = hold_nib[FIRST_IDX];
            S_LO:    data_out_next = hold_nib[SECOND_IDX];
            default: data_out_next = '0;
        endcase
    end

    always_ff @(posedge clk_4f or posedge reset) begin
        if (reset) begin
            state_reg     <= S_IDLE;
            hold_reg      <= '0;
            valid_out_reg <= 1'b0;
            data_out_reg  <= '0;
            overflow_reg  <= 1'b0;
        end else begin
            state_reg     <= state_next;
            hold_reg      <= hold_next;
            valid_out_reg <= (state_next != S_IDLE);
            data_out_reg  <= data_out_next;
            if (drop) begin
                overflow_reg <= 1'b1;
            end
        end
    end

    assign bus.ready_out  = !full;
    assign bus.valid_out  = valid_out_reg;
    assign bus.data_out   = data_out_reg;
    assign bus.fifo_full  = full;
    assign bus.fifo_empty = empty;
    assign bus.overflow   = overflow_reg;

endmodule

// File: tb/tb_byte_a_nibble_fifo.sv
// Directed, table-driven bench for byte_a_nibble_fifo (DEPTH=4).
module tb_byte_a_nibble_fifo;

    logic clk_4f;
    logic reset;
    int   tests_run;
    int   tests_failed;

    byte_a_nibble_fifo_if bus ();

    byte_a_nibble_fifo #(.DEPTH(4)) dut (
        .clk_4f (clk_4f),
        .reset  (reset),
        .bus    (bus)
    );

    initial clk_4f = 1'b0;
    always #5 clk_4f = ~clk_4f;

    // ph: 0 = idle output, 1 = first nibble of eb, 2 = second nibble of eb
    typedef struct {
        logic       vin;
        logic [7:0] din;
        int         ph;
        logic [7:0] eb;
        logic       er;
        logic       ef;
        logic       ee;
        logic       eo;
    } vec_t;

    vec_t tbl [28];

    logic       collect;
    logic [3:0] got_q [$];

    function automatic logic [3:0] nib(input logic [7:0] b, input int ph);
`ifdef NIBBLE_LSN_FIRST_EN
        if (ph == 1) return b[3:0];
        if (ph == 2) return b[7:4];
`else
        if (ph == 1) return b[7:4];
        if (ph == 2) return b[3:0];
`endif
        return 4'h0;
    endfunction

    function automatic vec_t mk(input logic vin, input logic [7:0] din, input int ph,
                                input logic [7:0] eb, input logic er, input logic ef,
                                input logic ee, input logic eo);
        vec_t v;
        v.vin = vin; v.din = din; v.ph = ph; v.eb = eb;
        v.er = er; v.ef = ef; v.ee = ee; v.eo = eo;
        return v;
    endfunction

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic chk_outs(input string tag, input logic ev, input logic [3:0] ed,
                            input logic er, input logic ef, input logic ee, input logic eo);
        chk({tag, ".valid_out"},  8'(bus.valid_out),  8'(ev));
        chk({tag, ".data_out"},   8'(bus.data_out),   8'(ed));
        chk({tag, ".ready_out"},  8'(bus.ready_out),  8'(er));
        chk({tag, ".fifo_full"},  8'(bus.fifo_full),  8'(ef));
        chk({tag, ".fifo_empty"}, 8'(bus.fifo_empty), 8'(ee));
        chk({tag, ".overflow"},   8'(bus.overflow),   8'(eo));
    endtask

    always @(posedge clk_4f) begin
        #1;
        if (collect && bus.valid_out) got_q.push_back(bus.data_out);
    end

    task automatic do_reset();
        bus.valid_in = 1'b0;
        bus.data_in  = 8'h00;
        reset = 1'b1;
        repeat (2) @(posedge clk_4f);
        #3;
        reset = 1'b0;
        @(posedge clk_4f);
        #1;
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        collect      = 1'b0;
        bus.valid_in = 1'b0;
        bus.data_in  = 8'h00;
        reset        = 1'b1;

        // one byte, then three back-to-back, then fill past full and drain
        tbl[0]  = mk(1, 8'hA5, 0, 8'h00, 1, 0, 0, 0);
        tbl[1]  = mk(0, 8'h00, 1, 8'hA5, 1, 0, 1, 0);
        tbl[2]  = mk(0, 8'h00, 2, 8'hA5, 1, 0, 1, 0);
        tbl[3]  = mk(0, 8'h00, 0, 8'h00, 1, 0, 1, 0);
        tbl[4]  = mk(1, 8'h12, 0, 8'h00, 1, 0, 0, 0);
        tbl[5]  = mk(1, 8'h34, 1, 8'h12, 1, 0, 0, 0);
        tbl[6]  = mk(1, 8'h56, 2, 8'h12, 1, 0, 0, 0);
        tbl[7]  = mk(0, 8'h00, 1, 8'h34, 1, 0, 0, 0);
        tbl[8]  = mk(0, 8'h00, 2, 8'h34, 1, 0, 0, 0);
        tbl[9]  = mk(0, 8'h00, 1, 8'h56, 1, 0, 1, 0);
        tbl[10] = mk(0, 8'h00, 2, 8'h56, 1, 0, 1, 0);
        tbl[11] = mk(0, 8'h00, 0, 8'h00, 1, 0, 1, 0);
        tbl[12] = mk(1, 8'h80, 0, 8'h00, 1, 0, 0, 0);
        tbl[13] = mk(1, 8'h81, 1, 8'h80, 1, 0, 0, 0);
        tbl[14] = mk(1, 8'h82, 2, 8'h80, 1, 0, 0, 0);
        tbl[15] = mk(1, 8'h83, 1, 8'h81, 1, 0, 0, 0);
        tbl[16] = mk(1, 8'h84, 2, 8'h81, 1, 0, 0, 0);
        tbl[17] = mk(1, 8'h85, 1, 8'h82, 1, 0, 0, 0);
        tbl[18] = mk(1, 8'h86, 2, 8'h82, 0, 1, 0, 0);
        tbl[19] = mk(1, 8'h87, 1, 8'h83, 1, 0, 0, 1);
        tbl[20] = mk(0, 8'h00, 2, 8'h83, 1, 0, 0, 1);
        tbl[21] = mk(0, 8'h00, 1, 8'h84, 1, 0, 0, 1);
        tbl[22] = mk(0, 8'h00, 2, 8'h84, 1, 0, 0, 1);
        tbl[23] = mk(0, 8'h00, 1, 8'h85, 1, 0, 0, 1);
        tbl[24] = mk(0, 8'h00, 2, 8'h85, 1, 0, 0, 1);
        tbl[25] = mk(0, 8'h00, 1, 8'h86, 1, 0, 1, 1);
        tbl[26] = mk(0, 8'h00, 2, 8'h86, 1, 0, 1, 1);
        tbl[27] = mk(0, 8'h00, 0, 8'h00, 1, 0, 1, 1);

        #2;
        chk_outs("reset", 1'b0, 4'h0, 1'b1, 1'b0, 1'b1, 1'b0);
        $display("[TB] reset: valid_out=%b data_out=%h ready_out=%b empty=%b",
                 bus.valid_out, bus.data_out, bus.ready_out, bus.fifo_empty);
        do_reset();

        for (int i = 0; i < 28; i++) begin
            bus.valid_in = tbl[i].vin;
            bus.data_in  = tbl[i].din;
            @(posedge clk_4f);
            #1;
            $display("[TB] vec %0d: vin=%b din=%h -> valid=%b data=%h ready=%b full=%b empty=%b ovf=%b",
                     i, tbl[i].vin, tbl[i].din, bus.valid_out, bus.data_out, bus.ready_out,
                     bus.fifo_full, bus.fifo_empty, bus.overflow);
            chk_outs($sformatf("vec%0d", i), (tbl[i].ph != 0), nib(tbl[i].eb, tbl[i].ph),
                     tbl[i].er, tbl[i].ef, tbl[i].ee, tbl[i].eo);
        end

        // pointer wrap at one byte per two cycles
        do_reset();
        got_q.delete();
        collect = 1'b1;
        for (int b = 0; b < 10; b++) begin
            bus.valid_in = 1'b1;
            bus.data_in  = 8'(b);
            @(posedge clk_4f);
            #1;
            bus.valid_in = 1'b0;
            @(posedge clk_4f);
            #1;
            $display("[TB] wrap push %h: overflow=%b", 8'(b), bus.overflow);
        end
        repeat (4) @(posedge clk_4f);
        #2;
        collect = 1'b0;
        chk("wrap.overflow", 8'(bus.overflow), 8'h0);
        chk("wrap.count", 8'(got_q.size()), 8'd20);
        if (got_q.size() == 20) begin
            for (int b = 0; b < 10; b++) begin
                chk($sformatf("wrap.nib%0d", 2*b),   8'(got_q[2*b]),   8'(nib(8'(b), 1)));
                chk($sformatf("wrap.nib%0d", 2*b+1), 8'(got_q[2*b+1]), 8'(nib(8'(b), 2)));
            end
        end

        // reset asserted asynchronously while in S_LO with three bytes queued
        do_reset();
        for (int b = 0; b < 5; b++) begin
            bus.valid_in = 1'b1;
            bus.data_in  = 8'hC1 + 8'(b);
            @(posedge clk_4f);
            #1;
        end
        bus.valid_in = 1'b0;
        chk_outs("midrst.pre", 1'b1, nib(8'hC2, 2), 1'b1, 1'b0, 1'b0, 1'b0);
        #2;
        reset = 1'b1;
        #1;
        chk_outs("midrst.async", 1'b0, 4'h0, 1'b1, 1'b0, 1'b1, 1'b0);
        $display("[TB] mid-stream reset: valid_out=%b data_out=%h empty=%b",
                 bus.valid_out, bus.data_out, bus.fifo_empty);
        #2;
        reset = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk_4f);
            #1;
            chk($sformatf("midrst.post%0d.valid", c), 8'(bus.valid_out), 8'h0);
            chk($sformatf("midrst.post%0d.empty", c), 8'(bus.fifo_empty), 8'h1);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
